// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/r_valid bus master port between NrMasters requesters.
// Optional macro DM_BUS_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module dm_bus_arbiter #(
    parameter int NrMasters      = 2,
    parameter int BusWidth       = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrMasters-1:0]            req_i,
    input  logic [NrMasters-1:0]            we_i,
    input  logic [NrMasters*BusWidth-1:0]   addr_i,
    input  logic [NrMasters*BusWidth-1:0]   wdata_i,
    input  logic [NrMasters*BusWidth/8-1:0] be_i,
    output logic [NrMasters-1:0]            gnt_o,
    output logic [NrMasters-1:0]            r_valid_o,
    output logic [BusWidth-1:0]             r_rdata_o,
    output logic                            master_req_o,
    output logic [BusWidth-1:0]             master_add_o,
    output logic                            master_we_o,
    output logic [BusWidth-1:0]             master_wdata_o,
    output logic [BusWidth/8-1:0]           master_be_o,
    input  logic                            master_gnt_i,
    input  logic                            master_r_valid_i,
    input  logic [BusWidth-1:0]             master_r_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                            err_o
);
    localparam int IdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = BusWidth / 8;

    typedef enum logic {ARB, HOLD} state_e;

    state_e            r_state, w_state_nxt;
    logic [IdxW-1:0]   r_hold_idx, r_rr_ptr, w_sel;
    logic [IdxW-1:0]   r_fifo [MaxOutstanding];
    logic [PtrW-1:0]   r_wptr, r_rptr;
    logic [CntW-1:0]   r_count;
    logic              r_err;
    logic              w_any, w_req, w_push, w_pop, w_full, w_empty;
    int                w_cand;

    function automatic logic [PtrW-1:0] f_ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requester selection: frozen to the held index while a request waits for its grant
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_cand = 0;
`ifdef DM_BUS_ARB_PRIO0_EN
        if (req_i[0]) begin
            w_any = 1'b1;
        end
`endif
        for (int i = 1; i <= NrMasters; i++) begin
            w_cand = (int'(r_rr_ptr) + i) % NrMasters;
`ifdef DM_BUS_ARB_PRIO0_EN
            if (!w_any && req_i[w_cand] && (w_cand != 0)) begin
`else
            if (!w_any && req_i[w_cand]) begin
`endif
                w_sel = IdxW'(w_cand);
                w_any = 1'b1;
            end
        end
        if (r_state == HOLD) begin
            w_sel = r_hold_idx;
            w_any = req_i[r_hold_idx];
        end
    end

    assign w_full  = (r_count == CntW'(MaxOutstanding));
    assign w_empty = (r_count == '0);
    assign w_req   = !rst_i && w_any && !w_full;
    assign w_push  = w_req && master_gnt_i;
    assign w_pop   = !rst_i && master_r_valid_i && !w_empty;

    assign master_req_o   = w_req;
    assign master_add_o   = addr_i[w_sel*BusWidth +: BusWidth];
    assign master_wdata_o = wdata_i[w_sel*BusWidth +: BusWidth];
    assign master_be_o    = be_i[w_sel*BeW +: BeW];
    assign master_we_o    = we_i[w_sel];

    assign gnt_o         = w_push ? (NrMasters'(1) << w_sel) : '0;
    assign r_valid_o     = w_pop ? (NrMasters'(1) << r_fifo[r_rptr]) : '0;
    assign r_rdata_o     = master_r_rdata_i;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_req && !master_gnt_i) w_state_nxt = HOLD;
            HOLD:    if (!req_i[r_hold_idx] || master_gnt_i) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control state: round-robin pointer, FIFO pointers/count, sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= IdxW'(NrMasters - 1);
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_sel;
                r_wptr   <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (master_r_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data storage: the ID FIFO and the held index need no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_sel;
        end
        if (r_state == ARB && w_state_nxt == HOLD) begin
            r_hold_idx <= w_sel;
        end
    end
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter: stimulus queues expected grants/responses, a monitor pops and compares.
module tb_dm_bus_arbiter;
    localparam int N  = 3;
    localparam int BW = 32;
    localparam int MO = 4;
`ifdef DM_BUS_ARB_PRIO0_EN
    localparam bit P = 1'b1;
`else
    localparam bit P = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [31:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, we, gnt, rvalid;
    logic [N*BW-1:0]   addr, wdata;
    logic [N*BW/8-1:0] be;
    logic [BW-1:0]     rdata, madd, mwdata, mrdata;
    logic [BW/8-1:0]   mbe;
    logic              mreq, mwe, mgnt, mrv, err;
    logic [2:0]        outst;

    int    total = 0;
    int    bad   = 0;
    int    gq[$];
    resp_t rq[$];

    dm_bus_arbiter #(.NrMasters(N), .BusWidth(BW), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rvalid),
        .r_rdata_o(rdata), .master_req_o(mreq), .master_add_o(madd),
        .master_we_o(mwe), .master_wdata_o(mwdata), .master_be_o(mbe),
        .master_gnt_i(mgnt), .master_r_valid_i(mrv), .master_r_rdata_i(mrdata),
        .outstanding_o(outst), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic g, input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        req    = r;
        mgnt   = g;
        mrv    = v;
        mrdata = d;
    endtask

    task automatic exp_gnt(input int i);
        gq.push_back(i);
    endtask

    task automatic exp_rsp(input int i, input logic [31:0] d);
        resp_t t;
        t.idx  = i;
        t.data = d;
        rq.push_back(t);
    endtask

    always @(negedge clk) begin
        int    e;
        resp_t t;
        if (gnt != '0) begin
            if (gq.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'(0));
            else begin
                e = gq.pop_front();
                chk("gnt", 64'(gnt), 64'(1) << e);
            end
        end
        if (rvalid != '0) begin
            if (rq.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 64'(0));
            else begin
                t = rq.pop_front();
                chk("rvalid", 64'(rvalid), 64'(1) << t.idx);
                chk("rdata", 64'(rdata), 64'(t.data));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; mgnt = 1'b0; mrv = 1'b0; mrdata = '0;
        we = 3'b010; be = '1;
        for (int m = 0; m < N; m++) begin
            addr[m*BW +: BW]  = 32'hA000_0000 + 32'(m) * 32'h100;
            wdata[m*BW +: BW] = 32'h5000_0000 + 32'(m);
        end

        // reset: everything suppressed even with active inputs
        drive(3'b011, 1'b1, 1'b1, 32'h99);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_mreq", 64'(mreq), 64'(0));
        drive(3'b000, 1'b0, 1'b0, 32'h0); rst = 1'b0;
        @(negedge clk);
        chk("rst_outst", 64'(outst), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        // alternating grants until full
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        @(negedge clk); chk("a1_mreq", 64'(mreq), 64'(1));
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(P ? 0 : 1);
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(P ? 0 : 1);
        drive(3'b011, 1'b1, 1'b1, 32'h11); exp_rsp(0, 32'h11);
        @(negedge clk);
        chk("full_outst", 64'(outst), 64'(4));
        chk("full_mreq", 64'(mreq), 64'(0));
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        @(negedge clk); chk("afterpop_outst", 64'(outst), 64'(3));
        drive(3'b000, 1'b0, 1'b1, 32'h21); exp_rsp(P ? 0 : 1, 32'h21);
        @(negedge clk); chk("refill_outst", 64'(outst), 64'(4));
        drive(3'b000, 1'b0, 1'b1, 32'h22); exp_rsp(0, 32'h22);
        drive(3'b000, 1'b0, 1'b1, 32'h23); exp_rsp(P ? 0 : 1, 32'h23);
        drive(3'b000, 1'b0, 1'b1, 32'h24); exp_rsp(0, 32'h24);
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("drain_outst", 64'(outst), 64'(0));
        chk("drain_err", 64'(err), 64'(0));

        // hold: requester 1 waits, requester 0 cannot steal
        drive(3'b010, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h1_mreq", 64'(mreq), 64'(1));
        chk("h1_add", 64'(madd), 64'(32'hA000_0100));
        drive(3'b011, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h2_add", 64'(madd), 64'(32'hA000_0100));
        chk("h2_wdata", 64'(mwdata), 64'(32'h5000_0001));
        chk("h2_we", 64'(mwe), 64'(1));
        chk("h2_be", 64'(mbe), 64'(4'hF));
        drive(3'b011, 1'b0, 1'b0, 32'h0);
        @(negedge clk); chk("h3_add", 64'(madd), 64'(32'hA000_0100));
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(1);
        @(negedge clk); chk("h4_add", 64'(madd), 64'(32'hA000_0100));
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        @(negedge clk); chk("h5_add", 64'(madd), 64'(32'hA000_0000));
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk); chk("h6_outst", 64'(outst), 64'(2));
        drive(3'b000, 1'b0, 1'b1, 32'h31); exp_rsp(1, 32'h31);
        drive(3'b001, 1'b1, 1'b1, 32'h32); exp_rsp(0, 32'h32); exp_gnt(0);
        @(negedge clk); chk("h8_outst", 64'(outst), 64'(1));
        drive(3'b000, 1'b0, 1'b1, 32'h33); exp_rsp(0, 32'h33);
        @(negedge clk); chk("h9_outst", 64'(outst), 64'(1));
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk); chk("h10_outst", 64'(outst), 64'(0));

        // in-order routing 0,1,1
        drive(3'b001, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        drive(3'b010, 1'b1, 1'b0, 32'h0); exp_gnt(1);
        drive(3'b010, 1'b1, 1'b0, 32'h0); exp_gnt(1);
        drive(3'b000, 1'b0, 1'b1, 32'hA); exp_rsp(0, 32'hA);
        @(negedge clk); chk("c4_outst", 64'(outst), 64'(3));
        drive(3'b000, 1'b0, 1'b1, 32'hB); exp_rsp(1, 32'hB);
        @(negedge clk); chk("c5_outst", 64'(outst), 64'(2));
        drive(3'b000, 1'b0, 1'b1, 32'hC); exp_rsp(1, 32'hC);
        @(negedge clk); chk("c6_outst", 64'(outst), 64'(1));
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("c7_outst", 64'(outst), 64'(0));
        chk("c7_err", 64'(err), 64'(0));

        // spurious response on empty FIFO
        drive(3'b000, 1'b0, 1'b1, 32'hDEAD);
        @(negedge clk);
        chk("sp_rvalid", 64'(rvalid), 64'(0));
        chk("sp_err_pre", 64'(err), 64'(0));
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk); chk("sp_err", 64'(err), 64'(1));
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk); chk("sp_err_sticky", 64'(err), 64'(1));

        // reset with two grants outstanding
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        drive(3'b001, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        drive(3'b000, 1'b0, 1'b0, 32'h0); rst = 1'b1;
        @(negedge clk);
        chk("d3_outst", 64'(outst), 64'(2));
        chk("d3_err", 64'(err), 64'(1));
        drive(3'b000, 1'b0, 1'b1, 32'h55); rst = 1'b0;
        @(negedge clk);
        chk("d4_outst", 64'(outst), 64'(0));
        chk("d4_err", 64'(err), 64'(0));
        chk("d4_rvalid", 64'(rvalid), 64'(0));
        drive(3'b011, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        @(negedge clk); chk("d5_err", 64'(err), 64'(1));

        // requesters 0 and 2 contending
        drive(3'b101, 1'b1, 1'b0, 32'h0); exp_gnt(P ? 0 : 2);
        drive(3'b101, 1'b1, 1'b0, 32'h0); exp_gnt(0);
        drive(3'b101, 1'b1, 1'b0, 32'h0); exp_gnt(P ? 0 : 2);
        drive(3'b101, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("e4_mreq", 64'(mreq), 64'(0));
        chk("e4_outst", 64'(outst), 64'(4));
        drive(3'b000, 1'b0, 1'b1, 32'h61); exp_rsp(0, 32'h61);
        drive(3'b000, 1'b0, 1'b1, 32'h62); exp_rsp(P ? 0 : 2, 32'h62);
        drive(3'b000, 1'b0, 1'b1, 32'h63); exp_rsp(0, 32'h63);
        drive(3'b000, 1'b0, 1'b1, 32'h64); exp_rsp(P ? 0 : 2, 32'h64);
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("e9_outst", 64'(outst), 64'(0));
        chk("e9_err", 64'(err), 64'(1));

        chk("gq_left", 64'(gq.size()), 64'(0));
        chk("rq_left", 64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
